// File: rtl/cache_controller_if.sv
// Pipeline/cache/SRAM bundle for cache_controller.
// master: surrounding pipeline, cache and SRAM side; slave: the controller.
interface cache_controller_if;
  logic [31:0] address;
  logic [31:0] wdata;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] rdata;
  logic        ready;
  logic [16:0] cache_address;
  logic [63:0] cache_write_data;
  logic        cache_read_en;
  logic        cache_write_en;
  logic        cache_invalidate;
  logic [31:0] cache_read_data;
  logic        cache_hit;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic        sram_r_en;
  logic        sram_w_en;
  logic [63:0] sram_rdata;
  logic        sram_ready;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  modport master (
    output address, wdata, mem_r_en, mem_w_en,
    output cache_read_data, cache_hit,
    output sram_rdata, sram_ready,
    input  rdata, ready,
    input  cache_address, cache_write_data,
    input  cache_read_en, cache_write_en, cache_invalidate,
    input  sram_address, sram_wdata, sram_r_en, sram_w_en,
    input  hit_count, miss_count
  );

  modport slave (
    input  address, wdata, mem_r_en, mem_w_en,
    input  cache_read_data, cache_hit,
    input  sram_rdata, sram_ready,
    output rdata, ready,
    output cache_address, cache_write_data,
    output cache_read_en, cache_write_en, cache_invalidate,
    output sram_address, sram_wdata, sram_r_en, sram_w_en,
    output hit_count, miss_count
  );
endinterface

// File: rtl/cache_controller.sv
// Write-through, no-allocate cache controller with zero-wait read hits.
// Define CACHE_STATS_EN to build saturating hit/miss counters.
module cache_controller #(
  parameter logic [31:0] ADDR_OFFSET = 32'd1024
) (
  input logic         clk,
  input logic         rst,
  cache_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_WAIT = 2'd2
  } state_t;

  state_t      state;
  state_t      state_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        capture;
  logic        hit_evt;
  logic        miss_evt;
  logic [31:0] sel_addr;
  logic [31:0] off;
  logic        unused_off;

  assign sel_addr = (state == IDLE) ? bus.address : addr_q;
  assign off      = sel_addr - ADDR_OFFSET;
  assign unused_off = ^{off[31:19], off[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_d;
      if (capture) begin
        addr_q  <= bus.address;
        wdata_q <= bus.wdata;
      end
    end
  end

  always_comb begin
    state_d              = state;
    capture              = 1'b0;
    hit_evt              = 1'b0;
    miss_evt             = 1'b0;
    bus.ready            = 1'b1;
    bus.rdata            = '0;
    bus.cache_address    = off[18:2];
    bus.cache_write_data = bus.sram_rdata;
    bus.cache_read_en    = 1'b0;
    bus.cache_write_en   = 1'b0;
    bus.cache_invalidate = 1'b0;
    bus.sram_address     = addr_q;
    bus.sram_wdata       = wdata_q;
    bus.sram_r_en        = 1'b0;
    bus.sram_w_en        = 1'b0;
    // Outputs are forced quiet while reset is held, whatever the inputs.
    if (rst) begin
      case (state)
        IDLE: begin
          bus.sram_address = bus.address;
          bus.sram_wdata   = bus.wdata;
          if (bus.mem_w_en) begin
            bus.cache_invalidate = 1'b1;
            bus.sram_w_en        = 1'b1;
            bus.ready            = 1'b0;
            capture              = 1'b1;
            state_d              = WRITE_WAIT;
          end else if (bus.mem_r_en) begin
            bus.cache_read_en = 1'b1;
            if (bus.cache_hit) begin
              bus.rdata = bus.cache_read_data;
              hit_evt   = 1'b1;
            end else begin
              bus.ready     = 1'b0;
              bus.sram_r_en = 1'b1;
              capture       = 1'b1;
              miss_evt      = 1'b1;
              state_d       = READ_WAIT;
            end
          end
        end
        READ_WAIT: begin
          bus.sram_r_en = 1'b1;
          bus.ready     = 1'b0;
          if (bus.sram_ready) begin
            bus.cache_write_en = 1'b1;
            bus.rdata = off[2] ? bus.sram_rdata[63:32]
                               : bus.sram_rdata[31:0];
            bus.ready = 1'b1;
            state_d   = IDLE;
          end
        end
        WRITE_WAIT: begin
          bus.sram_w_en = 1'b1;
          bus.ready     = 1'b0;
          if (bus.sram_ready) begin
            bus.ready = 1'b1;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  logic [15:0] hits;
  logic [15:0] misses;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hits   <= '0;
      misses <= '0;
    end else begin
      if (hit_evt && hits != 16'hFFFF)
        hits <= hits + 16'd1;
      if (miss_evt && misses != 16'hFFFF)
        misses <= misses + 16'd1;
    end
  end

  assign bus.hit_count  = hits;
  assign bus.miss_count = misses;
`else
  logic unused_evt;
  assign unused_evt     = hit_evt ^ miss_evt;
  assign bus.hit_count  = '0;
  assign bus.miss_count = '0;
`endif

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 Parameter ADDR_OFFSET, default 1024, is the data-memory base address subtracted from every request address.
REQ-002 clk  input  1  system clock; every state element updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 address  input  32  memory-stage byte address.
REQ-005 wdata  input  32  memory-stage store data.
REQ-006 mem_r_en / mem_w_en  input  1 each  memory-stage load / store request.
REQ-007 rdata  output  32  load result.
REQ-008 ready  output  1  request complete; while low, the pipeline stalls and holds its inputs.
REQ-009 cache_address  output  17  cache index {tag[9:0], row[5:0], col}.
REQ-010 cache_write_data  output  64  line fill data.
REQ-011 cache_read_en / cache_write_en / cache_invalidate  output  1 each  cache commands.
REQ-012 cache_read_data  input  32; cache_hit  input  1  cache response, combinational from cache_address.
REQ-013 sram_address  output  32; sram_wdata  output  32; sram_r_en / sram_w_en  output  1 each  SRAM-controller request.
REQ-014 sram_rdata  input  64; sram_ready  input  1  SRAM-controller response.
REQ-015 hit_count / miss_count  output  16 each  statistics counters (see Configuration).

Function
REQ-016 The index is (address - ADDR_OFFSET)[18:2], and col selects the 32-bit half of a 64-bit line (0 = [31:0]).
REQ-017 The FSM has three states, IDLE, READ_WAIT and WRITE_WAIT.
REQ-018 In IDLE with no request, ready=1, all cache and SRAM enables are 0, and the state stays IDLE.
REQ-019 On a read hit in IDLE (mem_r_en=1, cache_hit=1): cache_read_en=1, rdata=cache_read_data and ready=1 in the same cycle (zero-wait), and the state stays IDLE.
REQ-020 On a read miss in IDLE: ready=0, sram_r_en=1, address and wdata are registered, and the next state is READ_WAIT.
REQ-021 In READ_WAIT: sram_r_en=1 and sram_address equals the registered address until sram_ready is sampled high.
REQ-022 In the sram_ready cycle of READ_WAIT: cache_write_en=1, cache_write_data=sram_rdata, rdata equals the col-selected half of sram_rdata, ready=1, and the next state is IDLE.
REQ-023 Stores are write-through no-allocate.
REQ-024 On mem_w_en=1 in IDLE: cache_invalidate=1 for that single cycle only, sram_w_en=1 with sram_wdata=wdata, ready=0, and the next state is WRITE_WAIT.
REQ-025 In WRITE_WAIT: sram_w_en=1 with the registered address and data; on sram_ready, ready=1 and the next state is IDLE; cache_invalidate and cache_write_en stay 0.
REQ-026 When mem_r_en and mem_w_en are both 1, the store takes priority.
REQ-027 sram_ready in IDLE is ignored.
REQ-028 sram_ready already high on the first wait-state cycle completes the request in that cycle, giving a minimum miss latency of 2 cycles.
REQ-029 Every cache and SRAM enable is a pure function of state and inputs; at most one of cache_read_en, cache_write_en and cache_invalidate is high in any cycle.

Reset
REQ-030 rst low forces IDLE immediately, including mid-transaction, clears the registered address and data, and clears both counters.
REQ-031 During reset: ready=1, rdata=0, and all cache and SRAM enables are 0.
REQ-032 A transaction in flight is abandoned; the pipeline reissues it after reset.

Configuration
REQ-033 With CACHE_STATS_EN defined, hit_count increments on each IDLE read hit and miss_count on each read-miss entry to READ_WAIT; both saturate at 16'hFFFF and stores do not count.
REQ-034 Without CACHE_STATS_EN, hit_count and miss_count are tied to 0 and no counter flops exist.

Verification
REQ-035 Cold read of 0x400 with sram_ready asserted 5 cycles later -> ready low for 5 cycles, one cache_write_en pulse, rdata = sram_rdata[31:0].
REQ-036 Immediate reread of 0x404 with cache_hit=1 -> ready=1 in the same cycle, cache_read_en=1, rdata=cache_read_data, no SRAM request.
REQ-037 Store of 0xDEADBEEF to 0x404 with a 3-cycle SRAM delay -> cache_invalidate high for exactly 1 cycle, sram_w_en high for 4 cycles, then ready=1.
REQ-038 mem_r_en=mem_w_en=1 -> the store path is taken and there is no sram_r_en.
REQ-039 rst pulled low during READ_WAIT -> IDLE the same cycle, sram_r_en=0, ready=1, and no cache_write_en.
REQ-040 With CACHE_STATS_EN defined, 3 hits and 2 misses -> hit_count=3, miss_count=2.
